ip_tx_framer: RTL and testbench
===============================

IP_TX_FRAMER -- requirements
Module: ip_tx_framer

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 1480, which is the largest accepted payload byte count; frames with a larger payload are dropped.
REQ-002 SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port enable, input, 1 bit: when low, new frames are not started.
REQ-005 SHALL have ports din_dout (input, 8), din_empty (input, 1) and din_read (output, 1): the first-word-fall-through byte FIFO read side; din_dout is valid whenever din_empty=0, and din_read pops one byte.
REQ-006 SHALL have ports hdr_valid (output, 1) and hdr_ready (input, 1): the IP header handshake.
REQ-007 SHALL have header output ports dest_ip (32), source_ip (32), protocol (8), ttl (8), length (16), dscp (6) and ecn (2).
REQ-008 SHALL have AXI-stream payload ports tdata (output, 8), tvalid (output, 1), tready (input, 1) and tlast (output, 1).
REQ-009 SHALL have port drop_cnt, output, 16 bits: the count of dropped frames.

Function
REQ-010 SHALL use this input frame format: a 12-byte descriptor followed by the payload bytes.
  - Descriptor: dest_ip[4], source_ip[4], protocol[1], ttl[1], length[2].
  - Multi-byte fields are big-endian: the first byte goes to the MSB.
REQ-011 SHALL treat length as the total IP length; the payload count is length-20, computed in 16 bits.
REQ-012 SHALL implement states IDLE, DESC, HDR, PAY and DROP.
REQ-013 SHALL behave in IDLE as follows:
  - din_read=0.
  - If enable=1 and din_empty=0, go to DESC next cycle with the byte counter cleared.
REQ-014 SHALL behave in DESC as follows:
  - din_read = ~din_empty.
  - Each popped byte is shifted into the descriptor register and the byte counter increments.
  - On the 12th pop, the next state is decided from the length just completed, per REQ-015.
REQ-015 SHALL choose the state after DESC as follows:
  - length<=20 or length-20>MAX_PAYLOAD: go to DROP with remaining=length-20 (saturated at 0 if length<20).
  - Otherwise: go to HDR.
REQ-016 SHALL behave in HDR as follows:
  - hdr_valid=1, and the header fields are stable from the descriptor register.
  - dscp=0 and ecn=0 always.
  - On hdr_valid&hdr_ready, go to PAY with remaining=length-20.
REQ-017 SHALL behave in PAY as follows:
  - tvalid = ~din_empty; tdata = din_dout; din_read = tvalid&tready.
  - tlast = (remaining==1).
  - Each transfer decrements remaining; the transfer with tlast returns the block to IDLE.
REQ-018 SHALL behave in DROP as follows:
  - din_read = ~din_empty while remaining>0; each pop decrements remaining.
  - When remaining==0, go to IDLE.
  - drop_cnt increments by 1 on entry to DROP and saturates at 0xFFFF.
REQ-019 SHALL give PAY and DROP zero-latency pass-through: a byte available in cycle N is transferred in cycle N when tready=1.
REQ-020 SHALL throttle output only through tvalid when din_empty=1 mid-payload; tlast shall never assert without tvalid.
REQ-021 SHALL sample enable only in IDLE; deasserting enable mid-frame lets the current frame complete or drop normally.
REQ-022 SHALL never pop the FIFO in the same cycle as a state transition out of HDR; hdr_valid and tvalid are never high together.
REQ-023 SHALL allow back-to-back frames with at most one IDLE cycle between a tlast transfer and the next DESC pop.

Reset
REQ-024 SHALL, when rst_n=0, go asynchronously to IDLE with these values:
  - hdr_valid=0, tvalid=0, tlast=0, din_read=0.
  - The header field outputs are 0.
  - drop_cnt=0 and the counters are cleared.
REQ-025 SHALL discard any partial frame when reset asserts mid-frame; after release it starts from IDLE, and the upstream FIFO is reset by the same rst_n.
REQ-026 SHALL release reset synchronously in effect: the first state change happens on the first rising clk edge after rst_n rises.

Verification
REQ-027 SHALL be verified by these directed scenarios:
  - Basic frame: descriptor C0A80102, C0A80101, 11, 40, 001C, then payload 01..08 with tready=1. Expect one header with length=0x001C, protocol=0x11, ttl=0x40, dest_ip=0xC0A80102, source_ip=0xC0A80101. Then 8 beats with tlast only on 0x08, and drop_cnt=0.
  - Backpressure: hdr_ready held 0 for 5 cycles, then tready toggling 1/0. Expect the header held stable, no pops while hdr_valid waits, and the payload order preserved.
  - Runt: length=0x0014. Expect no hdr_valid, drop_cnt=1, no extra pops, and the next frame handled correctly.
  - Oversize: MAX_PAYLOAD=16 and length=0x0030 with 28 payload bytes. Expect all 28 bytes consumed, no output, and drop_cnt=1.
  - FIFO underflow mid-payload: din_empty=1 for 3 cycles. Expect tvalid=0 for those cycles and tlast still on the final byte.
  - Reset mid-payload after 3 of 8 bytes. Expect all outputs 0 immediately; with enable=0 after release, no pops occur.

Source files
------------

// File: rtl/ip_tx_framer.sv
// IP transmit framer: parses a 12-byte descriptor from a FWFT byte FIFO,
// presents the IP header over a valid/ready handshake, then streams or drops the payload.
module ip_tx_framer #(
    parameter int MAX_PAYLOAD = 1480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  din_dout,
    input  logic        din_empty,
    output logic        din_read,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [31:0] dest_ip,
    output logic [31:0] source_ip,
    output logic [7:0]  protocol,
    output logic [7:0]  ttl,
    output logic [15:0] length,
    output logic [5:0]  dscp,
    output logic [1:0]  ecn,
    output logic [7:0]  tdata,
    output logic        tvalid,
    input  logic        tready,
    output logic        tlast,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESC,
        S_HDR,
        S_PAY,
        S_DROP
    } state_t;

    localparam logic [15:0] MAX_PAY_W = 16'(MAX_PAYLOAD);
    localparam logic [15:0] IP_HDR_B  = 16'd20;

    state_t      r_state;
    state_t      w_next;
    logic [95:0] r_desc;
    logic [3:0]  r_cnt;
    logic [15:0] r_rem;
    logic [15:0] r_drop_cnt;

    logic [15:0] w_len_now;
    logic [15:0] w_pay_now;
    logic        w_reject;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Length completes on the 12th descriptor byte: its MSB is already in r_desc.
    assign w_len_now = {r_desc[7:0], din_dout};
    assign w_pay_now = w_len_now - IP_HDR_B;
    assign w_reject  = (w_len_now <= IP_HDR_B) || (w_pay_now > MAX_PAY_W);

    assign dest_ip   = r_desc[95:64];
    assign source_ip = r_desc[63:32];
    assign protocol  = r_desc[31:24];
    assign ttl       = r_desc[23:16];
    assign length    = r_desc[15:0];
    assign dscp      = 6'd0;
    assign ecn       = 2'd0;
    assign drop_cnt  = r_drop_cnt;

    always_comb begin
        w_next    = r_state;
        din_read  = 1'b0;
        hdr_valid = 1'b0;
        tvalid    = 1'b0;
        tdata     = 8'd0;
        tlast     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && !din_empty) w_next = S_DESC;
            end
            S_DESC: begin
                din_read = !din_empty;
                if (!din_empty && (r_cnt == 4'd11)) w_next = w_reject ? S_DROP : S_HDR;
            end
            S_HDR: begin
                hdr_valid = 1'b1;
                if (hdr_ready) w_next = S_PAY;
            end
            S_PAY: begin
                tvalid   = !din_empty;
                tdata    = din_dout;
                tlast    = !din_empty && (r_rem == 16'd1);
                din_read = !din_empty && tready;
                if (din_read && (r_rem == 16'd1)) w_next = S_IDLE;
            end
            S_DROP: begin
                din_read = !din_empty && (r_rem != 16'd0);
                if (r_rem == 16'd0) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_desc     <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: r_cnt <= '0;
                S_DESC: begin
                    if (din_read) begin
                        r_desc <= {r_desc[87:0], din_dout};
                        r_cnt  <= r_cnt + 4'd1;
                        if (w_next == S_DROP) begin
                            r_rem      <= (w_len_now < IP_HDR_B) ? 16'd0 : w_pay_now;
                            r_drop_cnt <= sat_inc(r_drop_cnt);
                        end
                    end
                end
                S_HDR: begin
                    if (hdr_ready) r_rem <= r_desc[15:0] - IP_HDR_B;
                end
                S_PAY, S_DROP: begin
                    if (din_read) r_rem <= r_rem - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_tx_framer.sv
// Directed bench for ip_tx_framer: a table of whole frames plus hand-written
// backpressure, underflow, back-to-back and mid-frame reset sequences.
module tb_ip_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        hdr_ready = 1'b1;
    logic        tready = 1'b1;
    logic [7:0]  din_dout;
    logic        din_empty;
    logic        din_read;
    logic        hdr_valid;
    logic [31:0] dest_ip, source_ip;
    logic [7:0]  protocol, ttl;
    logic [15:0] length;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [7:0]  tdata;
    logic        tvalid, tlast;
    logic [15:0] drop_cnt;

    ip_tx_framer #(.MAX_PAYLOAD(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .din_dout(din_dout), .din_empty(din_empty), .din_read(din_read),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .dest_ip(dest_ip), .source_ip(source_ip), .protocol(protocol), .ttl(ttl),
        .length(length), .dscp(dscp), .ecn(ecn),
        .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model, flushed by the shared reset
    logic [7:0] mem [1024];
    int wp = 0;
    int rp = 0;
    assign din_empty = (wp == rp);
    assign din_dout  = mem[rp[9:0]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rp <= wp;
        else if (din_read && (rp != wp)) rp <= rp + 1;
    end

    // Output monitor, sampled on the falling edge
    int nhdr = 0;
    int nbeat = 0;
    int viol = 0;
    logic [7:0]  bd [256];
    logic        bl [256];
    logic [95:0] h_cap = '0;
    logic [95:0] p_hdr = '0;
    logic        p_hv = 1'b0;
    logic        p_hr = 1'b0;
    wire  [95:0] w_hdr = {dest_ip, source_ip, protocol, ttl, length};

    always @(negedge clk) begin
        if (rst_n) begin
            if (hdr_valid && hdr_ready) begin
                h_cap <= w_hdr;
                nhdr  <= nhdr + 1;
            end
            if (tvalid && tready) begin
                bd[nbeat[7:0]] <= tdata;
                bl[nbeat[7:0]] <= tlast;
                nbeat <= nbeat + 1;
            end
            viol <= viol + ((hdr_valid && tvalid) ? 1 : 0)
                         + ((tlast && !tvalid) ? 1 : 0)
                         + ((hdr_valid && din_read) ? 1 : 0)
                         + ((hdr_valid && ({dscp, ecn} != 8'd0)) ? 1 : 0)
                         + ((hdr_valid && p_hv && !p_hr && (w_hdr != p_hdr)) ? 1 : 0);
        end
        p_hdr <= w_hdr;
        p_hv  <= hdr_valid;
        p_hr  <= hdr_ready;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp[9:0]] = b;
        wp = wp + 1;
    endtask

    task automatic push_frame(input logic [31:0] dst, input logic [31:0] src,
                              input logic [7:0] pr, input logic [7:0] tt,
                              input logic [15:0] len, input int npay, input logic [7:0] base);
        for (int k = 3; k >= 0; k--) push(dst[k*8 +: 8]);
        for (int k = 3; k >= 0; k--) push(src[k*8 +: 8]);
        push(pr);
        push(tt);
        push(len[15:8]);
        push(len[7:0]);
        for (int k = 0; k < npay; k++) push(base + 8'(k));
    endtask

    task automatic wait_drain(input string nm, input int maxc, output int cycles);
        bit done = 1'b0;
        cycles = 0;
        while (!done && cycles < maxc) begin
            tick();
            cycles++;
            if (rp == wp && !hdr_valid && !tvalid) done = 1'b1;
        end
        check({nm, " drained"}, 96'(done), 96'd1);
        tick();
        tick();
    endtask

    task automatic check_beats(input string nm, input int b0, input int n, input logic [7:0] base);
        logic [7:0] idx;
        for (int j = 0; j < n; j++) begin
            idx = 8'(b0 + j);
            check($sformatf("%s beat%0d", nm, j), {87'd0, bl[idx], bd[idx]},
                  {87'd0, (j == n - 1), base + 8'(j)});
        end
    endtask

    typedef struct {
        logic [31:0] dst;
        logic [31:0] src;
        logic [7:0]  pr;
        logic [7:0]  tt;
        logic [15:0] len;
        int          npay;
        logic [7:0]  base;
        int          exp_hdr;
        int          exp_drop;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int h0, b0, r0, cyc, eb;
        bit seen;

        tbl[0] = '{32'hC0A80102, 32'hC0A80101, 8'h11, 8'h40, 16'h001C,  8, 8'h01, 1, 0};
        tbl[1] = '{32'h01010101, 32'h02020202, 8'h11, 8'h40, 16'h0014,  0, 8'h00, 0, 1};
        tbl[2] = '{32'h0A000001, 32'h0A000002, 8'h06, 8'h80, 16'h0018,  4, 8'h10, 1, 1};
        tbl[3] = '{32'h0B000001, 32'h0B000002, 8'h11, 8'h01, 16'h0030, 28, 8'h20, 0, 2};
        tbl[4] = '{32'h0C000001, 32'h0C000002, 8'h11, 8'h02, 16'h0024, 16, 8'h40, 1, 2};
        tbl[5] = '{32'h0D000001, 32'h0D000002, 8'h11, 8'h03, 16'h0025, 17, 8'h60, 0, 3};
        tbl[6] = '{32'h0E000001, 32'h0E000002, 8'h11, 8'h04, 16'h0010,  0, 8'h00, 0, 4};
        tbl[7] = '{32'h0F000001, 32'h0F000002, 8'h01, 8'h05, 16'h0015,  1, 8'hA5, 1, 4};

        #1 rst_n = 1'b0;
        #3;
        check("reset hdr_valid", 96'(hdr_valid), 96'd0);
        check("reset tvalid", 96'(tvalid), 96'd0);
        check("reset tlast", 96'(tlast), 96'd0);
        check("reset din_read", 96'(din_read), 96'd0);
        check("reset header", 96'(w_hdr), 96'd0);
        check("reset drop_cnt", 96'(drop_cnt), 96'd0);
        tick();
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            h0 = nhdr;
            b0 = nbeat;
            push_frame(tbl[i].dst, tbl[i].src, tbl[i].pr, tbl[i].tt, tbl[i].len,
                       tbl[i].npay, tbl[i].base);
            wait_drain($sformatf("v%0d", i), 200, cyc);
            check($sformatf("v%0d header count", i), 96'(nhdr - h0), 96'(tbl[i].exp_hdr));
            if (tbl[i].exp_hdr == 1)
                check($sformatf("v%0d header", i), h_cap,
                      {tbl[i].dst, tbl[i].src, tbl[i].pr, tbl[i].tt, tbl[i].len});
            eb = (tbl[i].exp_hdr == 1) ? tbl[i].npay : 0;
            check($sformatf("v%0d beat count", i), 96'(nbeat - b0), 96'(eb));
            check_beats($sformatf("v%0d", i), b0, eb, tbl[i].base);
            check($sformatf("v%0d drop_cnt", i), 96'(drop_cnt), 96'(tbl[i].exp_drop));
        end

        // Header backpressure, then tready toggling
        hdr_ready = 1'b0;
        h0 = nhdr;
        b0 = nbeat;
        push_frame(32'h01020304, 32'h05060708, 8'h06, 8'h20, 16'h001C, 8, 8'h21);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            seen = hdr_valid;
        end
        check("bp header offered", 96'(seen), 96'd1);
        r0 = rp;
        repeat (5) tick();
        check("bp hdr_valid held", 96'(hdr_valid), 96'd1);
        check("bp no pops while waiting", 96'(rp), 96'(r0));
        check("bp header stable", 96'(w_hdr), {32'h01020304, 32'h05060708, 8'h06, 8'h20, 16'h001C});
        hdr_ready = 1'b1;
        tick();
        for (int k = 0; k < 40 && rp != wp; k++) begin
            tready = ~tready;
            tick();
        end
        tready = 1'b1;
        wait_drain("bp", 40, cyc);
        check("bp header count", 96'(nhdr - h0), 96'd1);
        check("bp beat count", 96'(nbeat - b0), 96'd8);
        check_beats("bp", b0, 8, 8'h21);

        // FIFO runs dry mid-payload for three cycles
        b0 = nbeat;
        push_frame(32'h11111111, 32'h22222222, 8'h11, 8'h40, 16'h001C, 4, 8'h41);
        for (int k = 0; k < 60 && (nbeat - b0) < 4; k++) tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("uf tvalid low %0d", k), 96'(tvalid), 96'd0);
            check($sformatf("uf tlast low %0d", k), 96'(tlast), 96'd0);
            tick();
        end
        for (int k = 4; k < 8; k++) push(8'h41 + 8'(k));
        wait_drain("uf", 40, cyc);
        check("uf beat count", 96'(nbeat - b0), 96'd8);
        check_beats("uf", b0, 8, 8'h41);

        // Back-to-back frames: at most one idle cycle between them
        h0 = nhdr;
        b0 = nbeat;
        push_frame(32'h33333333, 32'h44444444, 8'h11, 8'h40, 16'h0016, 2, 8'h81);
        push_frame(32'h55555555, 32'h66666666, 8'h11, 8'h40, 16'h0017, 3, 8'h91);
        wait_drain("b2b", 80, cyc);
        check("b2b header count", 96'(nhdr - h0), 96'd2);
        check("b2b beat count", 96'(nbeat - b0), 96'd5);
        check_beats("b2b f1", b0, 2, 8'h81);
        check_beats("b2b f2", b0 + 2, 3, 8'h91);
        check("b2b cycles within bound", 96'(cyc <= 33), 96'd1);

        // Reset after 3 of 8 payload bytes
        b0 = nbeat;
        push_frame(32'h77777777, 32'h88888888, 8'h11, 8'h40, 16'h001C, 8, 8'h61);
        for (int k = 0; k < 60 && (nbeat - b0) < 3; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst beats before reset", 96'(nbeat - b0), 96'd3);
        check("rst hdr_valid", 96'(hdr_valid), 96'd0);
        check("rst tvalid", 96'(tvalid), 96'd0);
        check("rst tlast", 96'(tlast), 96'd0);
        check("rst din_read", 96'(din_read), 96'd0);
        check("rst header", 96'(w_hdr), 96'd0);
        check("rst drop_cnt", 96'(drop_cnt), 96'd0);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        r0 = rp;
        push_frame(32'h99999999, 32'hAAAAAAAA, 8'h11, 8'h40, 16'h0015, 1, 8'h5A);
        repeat (10) tick();
        check("rst no pops while disabled", 96'(rp), 96'(r0));
        check("rst no header while disabled", 96'(hdr_valid), 96'd0);
        h0 = nhdr;
        b0 = nbeat;
        enable = 1'b1;
        wait_drain("rst", 60, cyc);
        check("rst next header", h_cap, {32'h99999999, 32'hAAAAAAAA, 8'h11, 8'h40, 16'h0015});
        check("rst next header count", 96'(nhdr - h0), 96'd1);
        check_beats("rst next", b0, 1, 8'h5A);

        check("protocol violations", 96'(viol), 96'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
